// File: rtl/ps2_fret_decoder.sv
// PS/2 keyboard receiver that turns make/break scan codes for five fret keys
// into held levels, with raw scan-code and frame-error strobes for diagnostics.
module ps2_fret_decoder #(
    parameter logic [7:0] KEY0_CODE      = 8'h1C,
    parameter logic [7:0] KEY1_CODE      = 8'h1B,
    parameter logic [7:0] KEY2_CODE      = 8'h23,
    parameter logic [7:0] KEY3_CODE      = 8'h2B,
    parameter logic [7:0] KEY4_CODE      = 8'h34,
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keys_held,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [39:0]   KEY_CODES = {KEY4_CODE, KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    ps2_clk_sync_reg, ps2_data_sync_reg;
    logic          clk_filt_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_flip, strobe, sample_bit;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic [TW-1:0] timeout_reg, timeout_next;
    logic [7:0]    scan_code_reg, scan_code_next;
    logic          scan_valid_reg, scan_valid_next;
    logic          frame_error_reg, frame_error_next;
    logic          break_reg, break_next;
    logic          ext_reg, ext_next;
    logic [4:0]    keys_reg, keys_next;
    logic [4:0]    key_match;
    logic          timeout_hit, clear_flags;

    // The filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
    assign filt_flip  = (ps2_clk_sync_reg[1] != clk_filt_reg) && (filt_cnt_reg == FILT_LAST);
    assign strobe     = filt_flip && clk_filt_reg;
    assign sample_bit = ps2_data_sync_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_sync_reg  <= 2'b11;
            ps2_data_sync_reg <= 2'b11;
            clk_filt_reg      <= 1'b1;
            filt_cnt_reg      <= '0;
        end else begin
            ps2_clk_sync_reg  <= {ps2_clk_sync_reg[0], ps2_clk};
            ps2_data_sync_reg <= {ps2_data_sync_reg[0], ps2_data};
            if (ps2_clk_sync_reg[1] == clk_filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_flip) begin
                clk_filt_reg <= ps2_clk_sync_reg[1];
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_match
            assign key_match[gi] = (scan_code_reg == KEY_CODES[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        bit_cnt_next     = bit_cnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        timeout_next     = timeout_reg;
        scan_code_next   = scan_code_reg;
        scan_valid_next  = 1'b0;
        frame_error_next = 1'b0;
        break_next       = break_reg;
        ext_next         = ext_reg;
        keys_next        = keys_reg;
        clear_flags      = 1'b0;
        timeout_hit      = (state_reg != S_IDLE) && !strobe && (timeout_reg == TO_MAX);

        if (state_reg == S_IDLE || strobe)
            timeout_next = '0;
        else if (timeout_reg != TO_MAX)
            timeout_next = timeout_reg + 1'b1;

        case (state_reg)
            S_IDLE: if (strobe) begin
                if (!sample_bit) begin
                    state_next   = S_DATA;
                    bit_cnt_next = '0;
                end else begin
                    frame_error_next = 1'b1;
                end
            end
            S_DATA: if (strobe) begin
                shift_next   = {sample_bit, shift_reg[7:1]};
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == 3'd7)
                    state_next = S_PARITY;
            end
            S_PARITY: if (strobe) begin
                parity_next = sample_bit;
                state_next  = S_STOP;
            end
            S_STOP: if (strobe) begin
                // Odd parity: data plus parity bit must hold an odd number of ones.
                if (sample_bit && (^{shift_reg, parity_reg})) begin
                    scan_code_next  = shift_reg;
                    scan_valid_next = 1'b1;
                end else begin
                    frame_error_next = 1'b1;
                    clear_flags      = 1'b1;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_next       = S_IDLE;
            frame_error_next = 1'b1;
            clear_flags      = 1'b1;
            shift_next       = '0;
            bit_cnt_next     = '0;
            timeout_next     = '0;
        end

        // Decode the byte published last cycle; prefix bytes only arm flags.
        if (scan_valid_reg) begin
            if (scan_code_reg == 8'hF0) begin
                break_next = 1'b1;
            end else if (scan_code_reg == 8'hE0) begin
                ext_next = 1'b1;
            end else begin
                if (!ext_reg)
                    keys_next = (keys_reg & ~key_match) | (key_match & {5{~break_reg}});
                break_next = 1'b0;
                ext_next   = 1'b0;
            end
        end

        if (clear_flags) begin
            break_next = 1'b0;
            ext_next   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            timeout_reg     <= '0;
            scan_code_reg   <= '0;
            scan_valid_reg  <= 1'b0;
            frame_error_reg <= 1'b0;
            break_reg       <= 1'b0;
            ext_reg         <= 1'b0;
            keys_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            timeout_reg     <= timeout_next;
            scan_code_reg   <= scan_code_next;
            scan_valid_reg  <= scan_valid_next;
            frame_error_reg <= frame_error_next;
            break_reg       <= break_next;
            ext_reg         <= ext_next;
            keys_reg        <= keys_next;
        end
    end

    assign keys_held   = keys_reg;
    assign scan_code   = scan_code_reg;
    assign scan_valid  = scan_valid_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_ps2_fret_decoder.sv
// Directed and randomized PS/2 frames checked against a key-state model that
// tracks break/extended prefixes and per-key held levels.
module tb_ps2_fret_decoder;

    localparam int HALF    = 20;    // half PS/2 bit period in clk cycles
    localparam int TIMEOUT = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [4:0] keys_held;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_error;

    ps2_fret_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keys_held(keys_held), .scan_code(scan_code),
        .scan_valid(scan_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Event monitor, sampled on the falling clk edge.
    int         sv_cnt = 0, fe_cnt = 0, both_cnt = 0, sv_len_max = 0, sv_run = 0;
    logic       sv_prev = 1'b0;
    logic [4:0] keys_at_sv = '0, keys_after_sv = '0;
    always @(negedge clk) begin
        if (sv_prev) keys_after_sv = keys_held;
        if (scan_valid) begin
            sv_cnt++;
            keys_at_sv = keys_held;
            sv_run++;
            if (sv_run > sv_len_max) sv_len_max = sv_run;
        end else begin
            sv_run = 0;
        end
        if (frame_error) fe_cnt++;
        if (scan_valid && frame_error) both_cnt++;
        sv_prev = scan_valid;
    end

    // Reference model state.
    logic [7:0] codes [5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
    logic [4:0] m_keys = '0;
    logic [7:0] m_code = '0;
    bit         m_brk = 0, m_ext = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // err: 0 clean, 1 parity flipped, 2 stop bit 0
    task automatic drive_frame(input logic [7:0] b, input int err);
        logic par;
        par = ~(^b);
        if (err == 1) par = ~par;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(err == 2 ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    // Start bit plus nbits data bits, then the lines go idle.
    task automatic drive_partial(input logic [7:0] b, input int nbits);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_code = b;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            if (!m_ext)
                for (int n = 0; n < 5; n++)
                    if (b == codes[n]) m_keys[n] = ~m_brk;
            m_brk = 0;
            m_ext = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input int err);
        int sv0, fe0;
        logic [4:0] prev;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        prev = m_keys;
        drive_frame(b, err);
        repeat (20) @(posedge clk);
        #1;
        if (err != 0) begin
            m_brk = 0;
            m_ext = 0;
        end else begin
            model_byte(b);
        end
        check("scan_valid_count", sv_cnt - sv0, (err == 0) ? 1 : 0);
        check("frame_error_count", fe_cnt - fe0, (err == 0) ? 0 : 1);
        check("scan_code", scan_code, m_code);
        check("keys_held", keys_held, m_keys);
        if (err == 0) begin
            check("keys_at_scan_valid", keys_at_sv, prev);
            check("keys_after_scan_valid", keys_after_sv, m_keys);
        end
        $display("frame byte=%02h err=%0d scan_code=%02h keys_held=%05b", b, err, scan_code, keys_held);
    endtask

    initial begin
        int sv0, fe0, r, e;
        logic [7:0] b;

        repeat (4) @(posedge clk);
        #1;
        check("reset_keys", keys_held, 5'b0);
        check("reset_scan_code", scan_code, 8'h00);
        check("reset_scan_valid", scan_valid, 1'b0);
        check("reset_frame_error", frame_error, 1'b0);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        // Press / release basics
        send(8'h1C, 0); check("t1_keys", keys_held, 5'b00001);
        send(8'hF0, 0); check("t2_break_only", keys_held, 5'b00001);
        send(8'h1C, 0); check("t2_release", keys_held, 5'b00000);
        send(8'h1B, 0); check("t3_s", keys_held, 5'b00010);
        send(8'h34, 0); check("t3_sg", keys_held, 5'b10010);
        send(8'hF0, 0);
        send(8'h1B, 0); check("t3_release_s", keys_held, 5'b10000);
        send(8'hF0, 0);
        send(8'h34, 0);

        // Bad frames; an error also drops a pending break prefix
        send(8'h1C, 1); check("t4_parity", keys_held, 5'b00000);
        send(8'h1C, 2); check("t4_stop", keys_held, 5'b00000);
        send(8'hF0, 0);
        send(8'h1C, 1);
        send(8'h1C, 0); check("t4_flags_cleared", keys_held, 5'b00001);
        send(8'hF0, 0);
        send(8'h1C, 0);

        // Timeout mid-frame, with a break prefix pending
        send(8'hF0, 0);
        sv0 = sv_cnt; fe0 = fe_cnt;
        drive_partial(8'h5A, 4);
        repeat (TIMEOUT + 200) @(posedge clk);
        #1;
        check("t5_timeout_fe", fe_cnt - fe0, 1);
        check("t5_timeout_sv", sv_cnt - sv0, 0);
        m_brk = 0; m_ext = 0;
        $display("frame partial timeout fe=%0d", fe_cnt - fe0);
        send(8'h23, 0); check("t5_after_timeout", keys_held, 5'b00100);
        send(8'hF0, 0);
        send(8'h23, 0);

        // Extended prefix suppresses mapping
        send(8'hE0, 0);
        send(8'h1C, 0); check("t6_extended", keys_held, 5'b00000);

        // Short clock glitch with data low must not look like a start bit
        sv0 = sv_cnt; fe0 = fe_cnt;
        ps2_data = 1'b0;
        @(posedge clk); ps2_clk = 1'b0;
        repeat (3) @(posedge clk); ps2_clk = 1'b1;
        repeat (5) @(posedge clk); ps2_data = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("t6_glitch_sv", sv_cnt - sv0, 0);
        check("t6_glitch_fe", fe_cnt - fe0, 0);
        $display("glitch 3 cycles sv=%0d fe=%0d", sv_cnt - sv0, fe_cnt - fe0);
        send(8'h2B, 0); check("t6_after_glitch", keys_held, 5'b01000);

        // Reset in the middle of a frame
        drive_partial(8'h1B, 3);
        @(posedge clk); reset = 1'b1;
        repeat (2) @(posedge clk); reset = 1'b0;
        #1;
        check("t6_rst_keys", keys_held, 5'b0);
        check("t6_rst_code", scan_code, 8'h00);
        check("t6_rst_sv", scan_valid, 1'b0);
        check("t6_rst_fe", frame_error, 1'b0);
        m_keys = '0; m_code = '0; m_brk = 0; m_ext = 0;
        $display("reset mid-frame keys_held=%05b scan_code=%02h", keys_held, scan_code);
        repeat (40) @(posedge clk);
        send(8'h1C, 0); check("t6_after_reset", keys_held, 5'b00001);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 8);
            case (r)
                0: b = 8'h1C;
                1: b = 8'h1B;
                2: b = 8'h23;
                3: b = 8'h2B;
                4: b = 8'h34;
                5: b = 8'hF0;
                6: b = 8'hE0;
                default: b = 8'($urandom);
            endcase
            r = $urandom_range(0, 19);
            e = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            send(b, e);
        end

        check("never_sv_and_fe", both_cnt, 0);
        check("scan_valid_one_cycle", sv_len_max, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
